// File: rtl/uart_rx_shift_if.sv
// ---------------------------------------------------------------------------
// uart_rx_shift_if
//   Bundles the receiver's control, serial line and character outputs so the
//   deserializer and the UART core connect through one port.
//
//   master : receiver side (uart_rx_shift). It reads the line and
//            configuration and drives the character/flag outputs.
//   slave  : core side. It drives the line and configuration and reads the
//            character/flag outputs.
//
//   Signals
//     enable_in   receiver enable
//     serial_in   asynchronous RX line, idle high
//     osm_sel_in  0: 16x oversampling, 1: 13x oversampling
//     wls_in      word length, data bits = 5 + wls_in
//     pen_in      parity enable
//     eps_in      even parity select
//     sp_in       stick parity
//     rbr_out     received character, bits above the word length are zero
//     valid_out   one-cycle pulse when character and flags update
//     pe_out      parity error
//     fe_out      framing error
//     bi_out      break indication
//     busy_out    receiver is inside a character
// ---------------------------------------------------------------------------
interface uart_rx_shift_if;
    logic       enable_in;
    logic       serial_in;
    logic       osm_sel_in;
    logic [1:0] wls_in;
    logic       pen_in;
    logic       eps_in;
    logic       sp_in;
    logic [7:0] rbr_out;
    logic       valid_out;
    logic       pe_out;
    logic       fe_out;
    logic       bi_out;
    logic       busy_out;

    modport master (
        input  enable_in, serial_in, osm_sel_in, wls_in, pen_in, eps_in, sp_in,
        output rbr_out, valid_out, pe_out, fe_out, bi_out, busy_out
    );

    modport slave (
        output enable_in, serial_in, osm_sel_in, wls_in, pen_in, eps_in, sp_in,
        input  rbr_out, valid_out, pe_out, fe_out, bi_out, busy_out
    );
endinterface

// File: rtl/uart_rx_shift.sv
// ---------------------------------------------------------------------------
// uart_rx_shift
//   UART receive deserializer. Oversamples the RX line on bclk_in, validates
//   the start bit at its centre, shifts in 5..8 data bits LSB first, checks
//   optional parity and the first stop bit, then presents the character and
//   error flags for one cycle on valid_out.
//
//   Ports
//     bclk_in   oversampling clock, rising edge
//     rstn_in   asynchronous active-low reset
//     bus       uart_rx_shift_if.master (line, configuration, outputs)
//
//   Build option
//     UART_RX_MAJORITY_EN  when defined, every bit decision is the 2-of-3
//                          majority of the line at the nominal sample point
//                          and the two cycles before it. When undefined a
//                          single sample at the nominal point is used.
// ---------------------------------------------------------------------------
module uart_rx_shift (
    input  logic            bclk_in,
    input  logic            rstn_in,
    uart_rx_shift_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Expected parity bit; data bits above the word length are zero so the
    // whole byte can be reduced.
    function automatic logic exp_parity(input logic [7:0] data,
                                        input logic       eps,
                                        input logic       sp);
        logic par;
        if (sp) begin
            par = ~eps;
        end else begin
            par = (^data) ^ ~eps;
        end
        return par;
    endfunction

`ifdef UART_RX_MAJORITY_EN
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
`endif

    state_t     state_q, state_d;
    logic       sync1_q, sync1_d;
    logic       rxd_q, rxd_d;
    logic       rxd_prev_q, rxd_prev_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shift_q, shift_d;
    logic       par_bit_q, par_bit_d;
    logic       stop_bit_q, stop_bit_d;
    logic       osm_q, osm_d;
    logic [1:0] wls_q, wls_d;
    logic       pen_q, pen_d;
    logic       eps_q, eps_d;
    logic       sp_q, sp_d;
    logic [7:0] rbr_q, rbr_d;
    logic       valid_q, valid_d;
    logic       pe_q, pe_d;
    logic       fe_q, fe_d;
    logic       bi_q, bi_d;
    logic       busy_q, busy_d;
`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q, hist_d;
`endif

    logic       sample_s;
    logic [3:0] osr_last_s;
    logic [3:0] half_last_s;
    logic [2:0] last_bit_s;

    // Bit decision and per-character timing constants.
    always_comb begin
`ifdef UART_RX_MAJORITY_EN
        // hist_q[0] is rxd one cycle ago, hist_q[1] two cycles ago, so at the
        // nominal point P this votes over P-2, P-1 and P.
        sample_s = maj3(rxd_q, hist_q[0], hist_q[1]);
`else
        sample_s = rxd_q;
`endif
        osr_last_s  = osm_q ? 4'd12 : 4'd15;
        half_last_s = osm_q ? 4'd5  : 4'd7;
        last_bit_s  = 3'd4 + {1'b0, wls_q};
    end

    // Next-state, datapath and output computation.
    always_comb begin
        state_d    = state_q;
        sync1_d    = bus.serial_in;
        rxd_d      = sync1_q;
        rxd_prev_d = rxd_q;
        cnt_d      = cnt_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        stop_bit_d = stop_bit_q;
        osm_d      = osm_q;
        wls_d      = wls_q;
        pen_d      = pen_q;
        eps_d      = eps_q;
        sp_d       = sp_q;
        rbr_d      = rbr_q;
        valid_d    = 1'b0;
        pe_d       = pe_q;
        fe_d       = fe_q;
        bi_d       = bi_q;
`ifdef UART_RX_MAJORITY_EN
        hist_d     = {hist_q[0], rxd_q};
`endif

        case (state_q)
            ST_IDLE: begin
                // A falling edge needs a high rxd just before it, so a line
                // still held low after a break cannot start a new character.
                if ((rxd_q == 1'b0) && (rxd_prev_q == 1'b1)) begin
                    state_d = ST_START;
                    cnt_d   = 4'd0;
                    shift_d = 8'h00;
                    osm_d   = bus.osm_sel_in;
                    wls_d   = bus.wls_in;
                    pen_d   = bus.pen_in;
                    eps_d   = bus.eps_in;
                    sp_d    = bus.sp_in;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == half_last_s) begin
                    if (sample_s == 1'b1) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d  = ST_DATA;
                        cnt_d    = 4'd0;
                        bitcnt_d = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == osr_last_s) begin
                    shift_d[bitcnt_q] = sample_s;
                    cnt_d             = 4'd0;
                    bitcnt_d          = bitcnt_q + 3'd1;
                    if (bitcnt_q == last_bit_s) begin
                        state_d = pen_q ? ST_PARITY : ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_PARITY: begin
                if (cnt_q == osr_last_s) begin
                    par_bit_d = sample_s;
                    cnt_d     = 4'd0;
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == osr_last_s) begin
                    stop_bit_d = sample_s;
                    cnt_d      = 4'd0;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                valid_d = 1'b1;
                rbr_d   = shift_q;
                pe_d    = pen_q & (par_bit_q != exp_parity(shift_q, eps_q, sp_q));
                fe_d    = ~stop_bit_q;
                bi_d    = (shift_q == 8'h00) & (~pen_q | ~par_bit_q) & ~stop_bit_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Disable aborts any character; published outputs keep their values.
        if (bus.enable_in == 1'b0) begin
            state_d  = ST_IDLE;
            cnt_d    = 4'd0;
            bitcnt_d = 3'd0;
            shift_d  = 8'h00;
            valid_d  = 1'b0;
            rbr_d    = rbr_q;
            pe_d     = pe_q;
            fe_d     = fe_q;
            bi_d     = bi_q;
        end else begin
            valid_d  = valid_d;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge bclk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q    <= ST_IDLE;
            sync1_q    <= 1'b1;
            rxd_q      <= 1'b1;
            rxd_prev_q <= 1'b1;
            cnt_q      <= 4'd0;
            bitcnt_q   <= 3'd0;
            shift_q    <= 8'h00;
            par_bit_q  <= 1'b0;
            stop_bit_q <= 1'b0;
            osm_q      <= 1'b0;
            wls_q      <= 2'd0;
            pen_q      <= 1'b0;
            eps_q      <= 1'b0;
            sp_q       <= 1'b0;
            rbr_q      <= 8'h00;
            valid_q    <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            bi_q       <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            hist_q     <= 2'b11;
`endif
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            rxd_q      <= rxd_d;
            rxd_prev_q <= rxd_prev_d;
            cnt_q      <= cnt_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            stop_bit_q <= stop_bit_d;
            osm_q      <= osm_d;
            wls_q      <= wls_d;
            pen_q      <= pen_d;
            eps_q      <= eps_d;
            sp_q       <= sp_d;
            rbr_q      <= rbr_d;
            valid_q    <= valid_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            bi_q       <= bi_d;
            busy_q     <= busy_d;
`ifdef UART_RX_MAJORITY_EN
            hist_q     <= hist_d;
`endif
        end
    end

    assign bus.rbr_out   = rbr_q;
    assign bus.valid_out = valid_q;
    assign bus.pe_out    = pe_q;
    assign bus.fe_out    = fe_q;
    assign bus.bi_out    = bi_q;
    assign bus.busy_out  = busy_q;

endmodule

// File: tb/tb_uart_rx_shift.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_shift
//   Scoreboard bench for uart_rx_shift. Stimulus tasks drive whole frames on
//   the serial line cycle by cycle and push the expected character, flags and
//   valid_out cycle into a queue; an independent monitor pops and compares on
//   every valid_out pulse.
// ---------------------------------------------------------------------------
module tb_uart_rx_shift;

    typedef struct {
        logic [7:0] rbr;
        logic       pe;
        logic       fe;
        logic       bi;
        int         cyc;
    } exp_t;

`ifdef UART_RX_MAJORITY_EN
    localparam bit MAJ = 1'b1;
`else
    localparam bit MAJ = 1'b0;
`endif

    logic bclk;
    logic rstn;
    int   cyc;
    int   checks;
    int   errors;
    logic [7:0] last_rbr;
    exp_t exp_q[$];
    exp_t mon_e;

    uart_rx_shift_if bus();

    uart_rx_shift dut (
        .bclk_in (bclk),
        .rstn_in (rstn),
        .bus     (bus)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    always @(posedge bclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge bclk);
            #1;
        end
    endtask

    // Reference: what a correct receiver reports for a frame.
    function automatic exp_t model(input logic osm, input logic [1:0] wls, input logic pen,
                                   input logic eps, input logic sp, input logic [7:0] data,
                                   input logic par, input logic stop, input bit glitch,
                                   input int n0);
        exp_t e;
        int nd, osr, half, ones;
        logic [7:0] mask, d;
        nd   = 5 + int'(wls);
        osr  = osm ? 13 : 16;
        half = osm ? 6 : 8;
        mask = 8'hFF >> (8 - nd);
        d    = data & mask;
        if (glitch && !MAJ) d = ~d & mask;
        ones = $countones(d) + (par ? 1 : 0);
        e.rbr = d;
        if (!pen)     e.pe = 1'b0;
        else if (sp)  e.pe = (par != !eps);
        else if (eps) e.pe = (ones % 2 != 0);
        else          e.pe = (ones % 2 == 0);
        e.fe  = !stop;
        e.bi  = (d == 8'h00) && (!pen || !par) && !stop;
        e.cyc = n0 + 2 + half + osr * (nd + (pen ? 1 : 0) + 1) + 1;
        return e;
    endfunction

    // Drive one frame; extra_low keeps the line low for that many more bit times.
    task automatic send_frame(input logic osm, input logic [1:0] wls, input logic pen,
                              input logic eps, input logic sp, input logic [7:0] data,
                              input logic par, input logic stop, input bit glitch,
                              input bit scramble, input int extra_low);
        int osr, half, nd, nbits, b;
        logic [11:0] bits;
        logic lvl;
        exp_t e;
        osr  = osm ? 13 : 16;
        half = osm ? 6 : 8;
        nd   = 5 + int'(wls);
        bus.osm_sel_in = osm;
        bus.wls_in     = wls;
        bus.pen_in     = pen;
        bus.eps_in     = eps;
        bus.sp_in      = sp;
        bits = 12'h000;
        for (int i = 0; i < nd; i++) bits[1 + i] = data[i];
        nbits = 1 + nd;
        if (pen) begin
            bits[nbits] = par;
            nbits++;
        end
        bits[nbits] = stop;
        nbits++;
        for (int t = 0; t < nbits * osr; t++) begin
            b   = t / osr;
            lvl = bits[b];
            if (glitch && b >= 1 && b <= nd && t == half + osr * b) lvl = ~lvl;
            if (scramble && t == osr * 3) begin
                bus.osm_sel_in = 1'($urandom_range(0, 1));
                bus.wls_in     = 2'($urandom_range(0, 3));
                bus.pen_in     = 1'($urandom_range(0, 1));
                bus.eps_in     = 1'($urandom_range(0, 1));
                bus.sp_in      = 1'($urandom_range(0, 1));
            end
            bus.serial_in = lvl;
            step(1);
            if (t == 0) begin
                e = model(osm, wls, pen, eps, sp, data, par, stop, glitch, cyc);
                exp_q.push_back(e);
                last_rbr = e.rbr;
            end
        end
        bus.serial_in = 1'b0;
        step(extra_low * osr);
        bus.serial_in = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) step(1);
        check(name, exp_q.size(), 0);
        step(4);
    endtask

    // Monitor: every valid_out pulse must match the oldest expectation.
    always @(negedge bclk) begin
        if (bus.valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: valid_out at cycle %0d with nothing expected rbr=0x%0h",
                         cyc, bus.rbr_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("rbr", bus.rbr_out, mon_e.rbr);
                check("pe", bus.pe_out, mon_e.pe);
                check("fe", bus.fe_out, mon_e.fe);
                check("bi", bus.bi_out, mon_e.bi);
                check("valid_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [1:0] w;
        logic o, p, e, s, par, stp;
        cyc      = 0;
        checks   = 0;
        errors   = 0;
        last_rbr = 8'h00;
        rstn     = 1'b0;
        bus.enable_in  = 1'b1;
        bus.serial_in  = 1'b1;
        bus.osm_sel_in = 1'b0;
        bus.wls_in     = 2'd3;
        bus.pen_in     = 1'b0;
        bus.eps_in     = 1'b0;
        bus.sp_in      = 1'b0;
        step(3);
        check("reset_rbr", bus.rbr_out, 8'h00);
        check("reset_valid", bus.valid_out, 1'b0);
        check("reset_flags", {bus.pe_out, bus.fe_out, bus.bi_out}, 3'b000);
        check("reset_busy", bus.busy_out, 1'b0);
        rstn = 1'b1;
        step(10);

        // 16x 8N1 0xA5, latency 155.
        send_frame(1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        step(5);
        // 13x, 5 bits, even parity, 0x13 with wrong then right parity bit.
        send_frame(1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 8'h13, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        step(3);
        send_frame(1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 8'h13, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        wait_drain("drain_directed");

        // 5-cycle low pulse: false start.
        bus.osm_sel_in = 1'b0;
        bus.wls_in     = 2'd3;
        bus.pen_in     = 1'b0;
        bus.serial_in  = 1'b0;
        step(5);
        bus.serial_in  = 1'b1;
        check("false_start_busy_high", bus.busy_out, 1'b1);
        step(20);
        check("false_start_busy_low", bus.busy_out, 1'b0);
        check("false_start_rbr_hold", bus.rbr_out, last_rbr);

        // Break: line low for 30 bit times, then a normal frame.
        send_frame(1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 20);
        check("break_idle_after", bus.busy_out, 1'b0);
        step(20);
        send_frame(1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        wait_drain("drain_break");

        // Glitch at each data sample point of 0x55.
        send_frame(1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        wait_drain("drain_glitch");

        // Reset in the middle of data bit 3.
        bus.serial_in = 1'b0;
        step(16);
        bus.serial_in = 1'b1;
        step(48);
        bus.serial_in = 1'b0;
        step(8);
        rstn = 1'b0;
        #1;
        check("midreset_rbr", bus.rbr_out, 8'h00);
        check("midreset_flags", {bus.valid_out, bus.pe_out, bus.fe_out, bus.bi_out}, 4'b0000);
        check("midreset_busy", bus.busy_out, 1'b0);
        bus.serial_in = 1'b1;
        step(2);
        rstn = 1'b1;
        step(20);
        send_frame(1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        wait_drain("drain_reset");

        // Enable dropped mid-character.
        bus.serial_in = 1'b0;
        step(40);
        bus.enable_in = 1'b0;
        bus.serial_in = 1'b1;
        step(2);
        check("disable_busy", bus.busy_out, 1'b0);
        check("disable_rbr_hold", bus.rbr_out, last_rbr);
        bus.enable_in = 1'b1;
        step(30);
        check("disable_still_idle", bus.busy_out, 1'b0);

        // Randomized frames with mid-frame configuration changes.
        for (int n = 0; n < 40; n++) begin
            o   = 1'($urandom_range(0, 1));
            w   = 2'($urandom_range(0, 3));
            p   = 1'($urandom_range(0, 1));
            e   = 1'($urandom_range(0, 1));
            s   = 1'($urandom_range(0, 3) == 0);
            d   = 8'($urandom);
            par = 1'($urandom_range(0, 1));
            stp = 1'($urandom_range(0, 7) != 0);
            send_frame(o, w, p, e, s, d, par, stp, 1'b0, 1'b1, 0);
            bus.serial_in = 1'b1;
            step(stp ? $urandom_range(0, 6) : $urandom_range(1, 6));
        end
        wait_drain("drain_random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
